instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the decode/control block.
- Owns the PC and issues halfword-addressed reads to instruction memory.
- Buffers returned 16-bit instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Consumes the control block's branch outputs (Branch, brSel, brEx) to redirect the PC and flush wrong-path fetches.

---
 rtl/cpu_fetch_pkg.sv | 27 ++
 rtl/instr_fetch_unit_fifo.sv | 68 ++++++
 rtl/instr_fetch_unit.sv | 156 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the fetch stage: branch-select codes, offset field widths,
// fetch FSM states and the branch-offset sign extension helper.
package cpu_fetch_pkg;

    localparam logic [1:0] BR_LINK   = 2'b00;
    localparam logic [1:0] BR_COND   = 2'b01;
    localparam logic [1:0] BR_UNCOND = 2'b10;
    localparam logic [1:0] BR_SEQ    = 2'b11;

    localparam int unsigned OFS_COND_W   = 8;
    localparam int unsigned OFS_UNCOND_W = 11;
    localparam int unsigned OFS_LINK_W   = 6;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH
    } fetch_state_t;

    // Sign-extends the low 'width' bits of an instruction word to 32 bits.
    function automatic logic [31:0] sext_offset(input logic [15:0] ins, input int unsigned width);
        logic [31:0] v;
        v = {16'h0000, ins} << (32 - width);
        return $signed(v) >>> (32 - width);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: small power-of-two FIFO holding {pc, instr} pairs between the
// instruction memory and decode; clear empties it in one cycle and beats push/pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    input  logic                    clear,
    output logic [WIDTH-1:0]        head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full, do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !clear && (!full || pop);
    assign do_pop  = pop && !clear && !empty;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues halfword reads, buffers responses and redirects on
// taken branches. Define FETCH_PERF_EN to add saturating flush/stall performance counters.
module instr_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter int              PC_W       = 16,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     instr,
    output logic [PC_W-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            redirect_valid,
    input  logic            Branch,
    input  logic [1:0]      brSel,
    input  logic            brEx,
    input  logic [PC_W-1:0] br_pc,
    input  logic [15:0]     br_instr,
    input  logic [PC_W-1:0] br_reg,
    output logic [PC_W-1:0] link_addr
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]     perf_flush_cnt,
    output logic [15:0]     perf_stall_cnt
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    logic             redirect, push, pop;
    logic [PC_W-1:0]  target;
    logic [31:0]      ofs;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic [PC_W+15:0] fifo_head;

    assign redirect = redirect_valid && Branch && (brEx || brSel != BR_SEQ);

    always_comb begin
        ofs = '0;
        case (brSel)
            BR_COND:   ofs = sext_offset(br_instr, OFS_COND_W);
            BR_UNCOND: ofs = sext_offset(br_instr, OFS_UNCOND_W);
            default:   ofs = sext_offset(br_instr, OFS_LINK_W);
        endcase
        target = brEx ? br_reg : (br_pc + PC_W'(1) + ofs[PC_W-1:0]);
    end

    // Buffer slots are reserved at issue time, so a response can always be pushed.
    assign imem_req  = (state_q != BOOT) &&
                       (SUM_W'(inflight_q) + SUM_W'(fifo_count) < SUM_W'(FIFO_DEPTH));
    assign imem_addr = pc_q;
    assign link_addr = br_pc + PC_W'(1);

    assign push        = imem_rvalid && (discard_q == '0) && !redirect;
    assign instr_valid = !fifo_empty && !redirect;
    assign pop         = instr_valid && instr_ready;
    assign instr       = fifo_empty ? '0 : fifo_head[15:0];
    assign instr_pc    = fifo_empty ? '0 : fifo_head[PC_W+15:16];

    always_comb begin
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        discard_d  = discard_q;
        inflight_d = inflight_q + CNT_W'(imem_req) - CNT_W'(imem_rvalid);

        if (redirect) begin
            pc_d      = target;
            resp_pc_d = target;
            // Everything still outstanding after this cycle is wrong-path, including
            // the request issued now with the old pc.
            discard_d = inflight_d;
        end else begin
            if (imem_req) pc_d = pc_q + PC_W'(1);
            if (push)     resp_pc_d = resp_pc_q + PC_W'(1);
            if (imem_rvalid && discard_q != '0) discard_d = discard_q - CNT_W'(1);
        end

        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            default: state_d = (discard_d != '0) ? FLUSH : RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PC_W + 16)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({resp_pc_q, imem_rdata}),
        .pop       (pop),
        .clear     (redirect),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

`ifdef FETCH_PERF_EN
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (redirect && flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
        if (state_q != BOOT && !instr_valid && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_flush_cnt = flush_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: an in-order memory model with random latency,
// an expected delivery stream derived from the branch rules, and a decoupled monitor.
module tb_instr_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid, Branch, brEx;
    logic [1:0]  brSel;
    logic [15:0] br_pc, br_instr, br_reg;
    logic [15:0] link_addr;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_flush_cnt, perf_stall_cnt;
`endif

    instr_fetch_unit #(
        .PC_W       (16),
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .Branch         (Branch),
        .brSel          (brSel),
        .brEx           (brEx),
        .br_pc          (br_pc),
        .br_instr       (br_instr),
        .br_reg         (br_reg),
        .link_addr      (link_addr)
`ifdef FETCH_PERF_EN
        ,
        .perf_flush_cnt (perf_flush_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [15:0] exp_q[$];
    logic [15:0] exp_addr;
    logic [15:0] redir_target;
    logic [15:0] last_deliv_pc;
    logic        redir_now = 1'b0;
    logic        rand_ready = 1'b0;
    int          lat_min = 1, lat_max = 1;
    int          cyc = 0;
    int          n_cmp = 0, n_bad = 0;
    int          n_deliv = 0;
    int          model_flush = 0;
    int          first_req_cyc = -1, first_valid_cyc = -1;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] ref_target(input logic [1:0] sel, input logic ex,
                                               input logic [15:0] bpc, input logic [15:0] binstr,
                                               input logic [15:0] breg);
        int off;
        if (ex) return breg;
        case (sel)
            2'b01: begin off = int'(binstr[7:0]);  if (off >= 128)  off -= 256;  end
            2'b10: begin off = int'(binstr[10:0]); if (off >= 1024) off -= 2048; end
            default: begin off = int'(binstr[5:0]); if (off >= 32) off -= 64; end
        endcase
        return 16'(int'(bpc) + 1 + off);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // In-order memory: each request returns after its own random latency, head first.
    always @(posedge clk) begin
        #1;
        imem_rvalid = 1'b0;
        if (reset && mq.size() != 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
    end

    // Monitor: checks issued addresses and every presented instruction against the model.
    always @(negedge clk) begin
        int lat;
        if (reset) begin
            if (imem_req) begin
                check("imem_addr", 32'(imem_addr), 32'(exp_addr));
                check("req_cap", 32'(mq.size() < DEPTH), 32'd1);
                lat = int'($urandom_range(lat_max, lat_min));
                mq.push_back('{addr: imem_addr, due: cyc + lat});
                exp_addr = exp_addr + 16'd1;
                if (first_req_cyc < 0) first_req_cyc = cyc;
            end
            if (redir_now) exp_addr = redir_target;
            if (instr_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                check("instr_pc", 32'(instr_pc), 32'(exp_q[0]));
                check("instr", 32'(instr), 32'(mem_word(exp_q[0])));
                if (instr_ready) begin
                    last_deliv_pc = instr_pc;
                    n_deliv++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic model_reset();
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        exp_addr    = RESET_PC;
        model_flush = 0;
        redir_now   = 1'b0;
        mq.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        Branch         = 1'b0;
        brSel          = 2'b00;
        brEx           = 1'b0;
        redir_now      = 1'b0;
        if (rand_ready) instr_ready = ($urandom_range(9, 0) < 7);
        while (exp_q.size() < 4) exp_q.push_back(exp_q[$] + 16'd1);
    endtask

    task automatic do_redirect(input logic rv, input logic br, input logic [1:0] sel,
                               input logic ex, input logic [15:0] bpc,
                               input logic [15:0] binstr, input logic [15:0] breg);
        logic [15:0] tgt;
        redirect_valid = rv;
        Branch         = br;
        brSel          = sel;
        brEx           = ex;
        br_pc          = bpc;
        br_instr       = binstr;
        br_reg         = breg;
        if (rv && br && (ex || sel != 2'b11)) begin
            tgt = ref_target(sel, ex, bpc, binstr, breg);
            exp_q.delete();
            exp_q.push_back(tgt);
            redir_target = tgt;
            redir_now    = 1'b1;
            model_flush++;
        end
        #1;
        check("link_addr", 32'(link_addr), 32'(bpc + 16'd1));
    endtask

    task automatic wait_deliv(input string name, input logic [15:0] exp_pc);
        int c0;
        c0 = n_deliv;
        for (int k = 0; k < 40; k++) begin
            step();
            if (n_deliv > c0) break;
        end
        check({name, "_arrived"}, 32'(n_deliv > c0), 32'd1);
        if (n_deliv > c0) check(name, 32'(last_deliv_pc), 32'(exp_pc));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int rel_cyc;
        logic [15:0] exp_next;
        logic        r_rv, r_br, r_ex;
        logic [1:0]  r_sel;

        reset = 1'b0;
        instr_ready = 1'b1;
        redirect_valid = 1'b0; Branch = 1'b0; brSel = 2'b00; brEx = 1'b0;
        br_pc = '0; br_instr = '0; br_reg = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_instr_pc", 32'(instr_pc), 32'd0);

        // Reset release with 1-cycle memory and decode always ready.
        rel_cyc = cyc;
        reset = 1'b1;
        repeat (10) step();
        check("boot_to_first_req", 32'(first_req_cyc - rel_cyc), 32'd1);
        check("req_to_first_valid", 32'(first_valid_cyc - first_req_cyc), 32'd2);
        check("sequential_deliveries", 32'(n_deliv >= 4), 32'd1);

        // Decode stall: buffer fills, requests stop, head held.
        instr_ready = 1'b0;
        repeat (5) step();
        check("stall_req_low", 32'(imem_req), 32'd0);
        check("stall_valid_held", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        repeat (6) step();

        // Conditional taken, backward offset.
        do_redirect(1'b1, 1'b1, 2'b01, 1'b0, 16'h0010, 16'h00FC, 16'h0000);
        wait_deliv("cond_target", 16'h000D);

        // BX with two requests outstanding on a 3-cycle memory.
        lat_min = 3; lat_max = 3;
        repeat (8) step();
        for (int k = 0; k < 20; k++) begin
            if (mq.size() == 2) break;
            step();
        end
        check("bx_two_inflight", 32'(mq.size()), 32'd2);
        do_redirect(1'b1, 1'b1, 2'b10, 1'b1, 16'h0123, 16'h07FF, 16'h0040);
        wait_deliv("bx_target", 16'h0040);

        // Not-taken branch leaves the stream alone.
        lat_min = 1; lat_max = 1;
        repeat (4) step();
        exp_next = exp_q[0];
        do_redirect(1'b1, 1'b1, 2'b11, 1'b0, 16'h0050, 16'h00FF, 16'h1234);
        wait_deliv("not_taken_seq", exp_next);

        // Sequential fetch across the top of the address space.
        do_redirect(1'b1, 1'b1, 2'b01, 1'b1, 16'h0000, 16'h0000, 16'hFFFE);
        wait_deliv("wrap_fffe", 16'hFFFE);
        wait_deliv("wrap_ffff", 16'hFFFF);
        wait_deliv("wrap_0000", 16'h0000);

        // Random traffic: ready, latency and branch fields all randomised.
        rand_ready = 1'b1;
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom_range(8, 0) == 0) begin
                r_rv  = 1'($urandom_range(1, 0));
                r_br  = ($urandom_range(3, 0) != 0);
                r_ex  = ($urandom_range(3, 0) == 0);
                r_sel = 2'($urandom_range(3, 0));
                do_redirect(r_rv, r_br, r_sel, r_ex, 16'($urandom), 16'($urandom), 16'($urandom));
            end
        end
        rand_ready = 1'b0;
        instr_ready = 1'b1;
        repeat (10) step();
`ifdef FETCH_PERF_EN
        check("perf_flush_random", 32'(perf_flush_cnt), 32'(model_flush));
`endif

        // Reset asserted while discarding stale responses.
        lat_min = 3; lat_max = 3;
        repeat (6) step();
        do_redirect(1'b1, 1'b1, 2'b10, 1'b1, 16'h0000, 16'h0000, 16'h0200);
        step();
        reset = 1'b0;
        model_reset();
        #1;
        check("midflush_imem_req", 32'(imem_req), 32'd0);
        check("midflush_instr_valid", 32'(instr_valid), 32'd0);
        check("midflush_instr", 32'(instr), 32'd0);
        check("midflush_instr_pc", 32'(instr_pc), 32'd0);
`ifdef FETCH_PERF_EN
        check("midflush_perf_flush", 32'(perf_flush_cnt), 32'd0);
        check("midflush_perf_stall", 32'(perf_stall_cnt), 32'd0);
`endif
        repeat (2) step();
        reset = 1'b1;
        wait_deliv("post_reset_first", RESET_PC);

        // Three taken redirects after a clean reset.
        for (int i = 0; i < 3; i++) begin
            repeat (5) step();
            do_redirect(1'b1, 1'b1, 2'b00, 1'b1, 16'h0000, 16'h0000, 16'(16'h0100 * (i + 1)));
            wait_deliv("perf_seq_target", 16'(16'h0100 * (i + 1)));
        end
`ifdef FETCH_PERF_EN
        check("perf_flush_three", 32'(perf_flush_cnt), 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
